// File: rtl/tx_fc_dllp_decoder_pkg.sv
// Shared flow-control types and the Gen5 credit scale helper.
// Used by the transmit-side FC DLLP decoder and the receive-side FC logic.
// Pure declarations, no state.
package tx_fc_dllp_decoder_pkg;

  typedef enum logic [1:0] {
    FC_P   = 2'd0,
    FC_NP  = 2'd1,
    FC_CPL = 2'd2,
    FC_X   = 2'd3
  } FC_type_t;

  typedef enum logic [1:0] {
    DLLP_INIT1  = 2'd0,
    DLLP_INIT2  = 2'd1,
    DLLP_UPDATE = 2'd2,
    DLLP_RSVD   = 2'd3
  } fc_dllp_kind_t;

  typedef enum logic [1:0] {
    FC_INIT1 = 2'd0,
    FC_INIT2 = 2'd1,
    FC_READY = 2'd2
  } fc_init_state_t;

  // Working width of the scale helper; callers cast down to their field width.
  localparam int FC_SCALE_W = 32;

  // Scale 0/1 leave the value alone, 2 multiplies by 4, 3 by 16; the result
  // is masked to 'width' bits so callers see a zero-extended field.
  function automatic logic [FC_SCALE_W-1:0] fc_scale(
    input logic [FC_SCALE_W-1:0] value,
    input logic [1:0]            scale,
    input int                    width
  );
    logic [FC_SCALE_W-1:0] shifted;
    logic [FC_SCALE_W-1:0] mask;
    case (scale)
      2'd2:    shifted = value << 2;
      2'd3:    shifted = value << 4;
      default: shifted = value;
    endcase
    for (int i = 0; i < FC_SCALE_W; i++) begin
      mask[i] = (i < width);
    end
    return shifted & mask;
  endfunction

endpackage

// File: rtl/tx_fc_dllp_decoder_scaler.sv
// Scales one raw FC credit field and flags a zero (infinite) raw value.
// Purely combinational, zero latency.
// No flow control; output follows input.
module tx_fc_scaler
  import tx_fc_dllp_decoder_pkg::*;
#(
  parameter int RAW_WIDTH = 8,
  parameter int OUT_WIDTH = 12
) (
  input  logic [RAW_WIDTH-1:0] raw,
  input  logic [1:0]           scale,
  output logic [OUT_WIDTH-1:0] scaled,
  output logic                 raw_zero
);

  // Scale and zero-extend; a raw value of zero advertises infinite credit.
  always_comb begin
    scaled   = OUT_WIDTH'(fc_scale(FC_SCALE_W'(raw), scale, OUT_WIDTH));
    raw_zero = (raw == '0);
  end

endmodule

// File: rtl/tx_fc_dllp_decoder.sv
// Decodes InitFC1/InitFC2/UpdateFC DLLPs into Tx_FC credit-limit updates and runs FC init.
// One cycle from accepted DLLP to TypeFC/HdrFC/DataFC; status flags registered alongside.
// No backpressure: every presented DLLP is consumed in the cycle it is valid.
module tx_fc_dllp_decoder
  import tx_fc_dllp_decoder_pkg::*;
#(
  parameter int FC_HDR_WIDTH  = 12,
  parameter int FC_DATA_WIDTH = 16,
  parameter int INIT_TIMEOUT  = 4096
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     dllp_valid,
  input  logic [1:0]               dllp_kind,
  input  logic [1:0]               dllp_type,
  input  logic [1:0]               dllp_hdr_scale,
  input  logic [1:0]               dllp_data_scale,
  input  logic [7:0]               dllp_hdr_fc,
  input  logic [11:0]              dllp_data_fc,
  output logic [1:0]               TypeFC,
  output logic [FC_HDR_WIDTH-1:0]  HdrFC,
  output logic [FC_DATA_WIDTH-1:0] DataFC,
  output logic                     fc_init_done,
  output logic [2:0]               hdr_inf,
  output logic [2:0]               data_inf,
  output logic                     fc_init_timeout,
  output logic                     fc_proto_err
);

  localparam int CNT_W = $clog2(INIT_TIMEOUT + 1);

  fc_init_state_t           state_q, state_d;
  logic [2:0]               mask_q, mask_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     timeout_q, timeout_d;
  FC_type_t                 type_q, type_d;
  logic [FC_HDR_WIDTH-1:0]  hdr_q, hdr_d;
  logic [FC_DATA_WIDTH-1:0] data_q, data_d;
  logic [2:0]               hdr_inf_q, hdr_inf_d;
  logic [2:0]               data_inf_q, data_inf_d;
  logic                     err_q, err_d;

  logic [FC_HDR_WIDTH-1:0]  hdr_scaled;
  logic [FC_DATA_WIDTH-1:0] data_scaled;
  logic                     hdr_zero, data_zero;
  logic                     do_update;
  fc_dllp_kind_t            kind;
  FC_type_t                 in_type;
  logic [2:0]               type_oh;

  tx_fc_scaler #(.RAW_WIDTH(8), .OUT_WIDTH(FC_HDR_WIDTH)) u_hdr_scaler (
    .raw      (dllp_hdr_fc),
    .scale    (dllp_hdr_scale),
    .scaled   (hdr_scaled),
    .raw_zero (hdr_zero)
  );

  tx_fc_scaler #(.RAW_WIDTH(12), .OUT_WIDTH(FC_DATA_WIDTH)) u_data_scaler (
    .raw      (dllp_data_fc),
    .scale    (dllp_data_scale),
    .scaled   (data_scaled),
    .raw_zero (data_zero)
  );

  // FC_X shifts the one-hot out entirely, so it never matches a mask bit.
  assign kind    = fc_dllp_kind_t'(dllp_kind);
  assign in_type = FC_type_t'(dllp_type);
  assign type_oh = 3'b001 << dllp_type;

  // Next-state, credit forwarding, infinite tracking and error detection.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
    type_d     = FC_X;
    hdr_d      = hdr_q;
    data_d     = data_q;
    hdr_inf_d  = hdr_inf_q;
    data_inf_d = data_inf_q;
    err_d      = 1'b0;
    do_update  = 1'b0;

    // The wait for InitFC1 is bounded only by a sticky flag; the FSM keeps waiting.
    if (state_q == FC_INIT1 && cnt_q != CNT_W'(INIT_TIMEOUT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    timeout_d = timeout_q | (cnt_d == CNT_W'(INIT_TIMEOUT));

    if (dllp_valid) begin
      if (in_type == FC_X) begin
        err_d = 1'b1;
      end else begin
        case (state_q)
          FC_INIT1: begin
            if (kind == DLLP_INIT1) begin
              // Repeated InitFC1 for a recorded type is normal retransmission.
              if ((mask_q & type_oh) == 3'b000) begin
                mask_d = mask_q | type_oh;
                type_d = in_type;
                hdr_d  = hdr_scaled;
                data_d = data_scaled;
                if (hdr_zero)  hdr_inf_d  = hdr_inf_q | type_oh;
                if (data_zero) data_inf_d = data_inf_q | type_oh;
              end
            end else begin
              err_d = 1'b1;
            end
          end
          FC_INIT2: begin
            if (kind == DLLP_INIT2) begin
              state_d = FC_READY;
            end else if (kind == DLLP_UPDATE) begin
              state_d   = FC_READY;
              do_update = 1'b1;
            end
          end
          FC_READY: begin
            if (kind == DLLP_UPDATE) do_update = 1'b1;
          end
          default: state_d = FC_INIT1;
        endcase
      end
    end

    // An infinite field keeps its limit; a nonzero value there is a protocol error.
    if (do_update) begin
      type_d = in_type;
      if ((hdr_inf_q & type_oh) != 3'b000) begin
        if (!hdr_zero) err_d = 1'b1;
      end else begin
        hdr_d = hdr_scaled;
      end
      if ((data_inf_q & type_oh) != 3'b000) begin
        if (!data_zero) err_d = 1'b1;
      end else begin
        data_d = data_scaled;
      end
    end

    if (state_q == FC_INIT1 && mask_d == 3'b111) begin
      state_d = FC_INIT2;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= FC_INIT1;
      mask_q     <= 3'b000;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
      type_q     <= FC_X;
      hdr_q      <= '0;
      data_q     <= '0;
      hdr_inf_q  <= 3'b000;
      data_inf_q <= 3'b000;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
      type_q     <= type_d;
      hdr_q      <= hdr_d;
      data_q     <= data_d;
      hdr_inf_q  <= hdr_inf_d;
      data_inf_q <= data_inf_d;
      err_q      <= err_d;
    end
  end

  assign TypeFC          = type_q;
  assign HdrFC           = hdr_q;
  assign DataFC          = data_q;
  assign fc_init_done    = (state_q == FC_READY);
  assign hdr_inf         = hdr_inf_q;
  assign data_inf        = data_inf_q;
  assign fc_init_timeout = timeout_q;
  assign fc_proto_err    = err_q;

endmodule

// File: tb/tb_tx_fc_dllp_decoder.sv
// Bench for tx_fc_dllp_decoder: vector tables plus hand-written reset/timeout sequences.
// Expected outputs are queued when a DLLP is driven and compared one cycle later.
// DUT has no backpressure; inputs are driven on the falling edge.
module tb_tx_fc_dllp_decoder;
  import tx_fc_dllp_decoder_pkg::*;

  logic        clk = 1'b0;
  logic        arst;
  logic        dllp_valid;
  logic [1:0]  dllp_kind;
  logic [1:0]  dllp_type;
  logic [1:0]  dllp_hdr_scale;
  logic [1:0]  dllp_data_scale;
  logic [7:0]  dllp_hdr_fc;
  logic [11:0] dllp_data_fc;
  logic [1:0]  TypeFC;
  logic [11:0] HdrFC;
  logic [15:0] DataFC;
  logic        fc_init_done;
  logic [2:0]  hdr_inf;
  logic [2:0]  data_inf;
  logic        fc_init_timeout;
  logic        fc_proto_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        valid;
    logic [1:0]  kind;
    logic [1:0]  typ;
    logic [1:0]  hs;
    logic [1:0]  ds;
    logic [7:0]  hfc;
    logic [11:0] dfc;
    logic [1:0]  e_typ;
    logic [11:0] e_hdr;
    logic [15:0] e_data;
    logic        e_err;
    logic        e_done;
  } vec_t;

  vec_t sb_q[$];
  vec_t tab_a[5];
  vec_t tab_b[14];

  tx_fc_dllp_decoder #(
    .FC_HDR_WIDTH  (12),
    .FC_DATA_WIDTH (16),
    .INIT_TIMEOUT  (16)
  ) dut (
    .clk             (clk),
    .arst            (arst),
    .dllp_valid      (dllp_valid),
    .dllp_kind       (dllp_kind),
    .dllp_type       (dllp_type),
    .dllp_hdr_scale  (dllp_hdr_scale),
    .dllp_data_scale (dllp_data_scale),
    .dllp_hdr_fc     (dllp_hdr_fc),
    .dllp_data_fc    (dllp_data_fc),
    .TypeFC          (TypeFC),
    .HdrFC           (HdrFC),
    .DataFC          (DataFC),
    .fc_init_done    (fc_init_done),
    .hdr_inf         (hdr_inf),
    .data_inf        (data_inf),
    .fc_init_timeout (fc_init_timeout),
    .fc_proto_err    (fc_proto_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [1:0] k, input logic [1:0] t,
                              input int hs, input int ds, input int h, input int d,
                              input logic [1:0] et, input int eh, input int ed,
                              input logic ee, input logic edn);
    vec_t r;
    r.valid  = v;
    r.kind   = k;
    r.typ    = t;
    r.hs     = 2'(hs);
    r.ds     = 2'(ds);
    r.hfc    = 8'(h);
    r.dfc    = 12'(d);
    r.e_typ  = et;
    r.e_hdr  = 12'(eh);
    r.e_data = 16'(ed);
    r.e_err  = ee;
    r.e_done = edn;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic run(input vec_t v, input string tag);
    vec_t e;
    dllp_valid      = v.valid;
    dllp_kind       = v.kind;
    dllp_type       = v.typ;
    dllp_hdr_scale  = v.hs;
    dllp_data_scale = v.ds;
    dllp_hdr_fc     = v.hfc;
    dllp_data_fc    = v.dfc;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".type"}, int'(TypeFC), int'(e.e_typ));
    chk({tag, ".hdr"},  int'(HdrFC),  int'(e.e_hdr));
    chk({tag, ".data"}, int'(DataFC), int'(e.e_data));
    chk({tag, ".err"},  int'(fc_proto_err), int'(e.e_err));
    chk({tag, ".done"}, int'(fc_init_done), int'(e.e_done));
    @(negedge clk);
    dllp_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst       = 1'b1;
    dllp_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    arst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    arst            = 1'b1;
    dllp_valid      = 1'b0;
    dllp_kind       = DLLP_INIT1;
    dllp_type       = FC_P;
    dllp_hdr_scale  = 2'd0;
    dllp_data_scale = 2'd0;
    dllp_hdr_fc     = 8'd0;
    dllp_data_fc    = 12'd0;

    // Basic InitFC1 sequence, then leaving FC_INIT2 with an UpdateFC.
    tab_a[0] = mk(1, DLLP_INIT1,  FC_P,   0, 0, 30, 1000, FC_P,   30, 1000, 0, 0);
    tab_a[1] = mk(1, DLLP_INIT1,  FC_NP,  0, 0, 15, 1000, FC_NP,  15, 1000, 0, 0);
    tab_a[2] = mk(1, DLLP_INIT1,  FC_CPL, 0, 0, 30, 1000, FC_CPL, 30, 1000, 0, 0);
    tab_a[3] = mk(1, DLLP_UPDATE, FC_NP,  0, 0, 20, 500,  FC_NP,  20, 500,  0, 1);
    tab_a[4] = mk(0, DLLP_INIT1,  FC_P,   0, 0, 0,  0,    FC_X,   20, 500,  0, 1);

    // Errors, scaling, duplicates and infinite credits.
    tab_b[0]  = mk(1, DLLP_UPDATE, FC_P,   0, 0, 9,   9,    FC_X,   0,    0,     1, 0);
    tab_b[1]  = mk(1, DLLP_INIT1,  FC_X,   0, 0, 9,   9,    FC_X,   0,    0,     1, 0);
    tab_b[2]  = mk(1, DLLP_INIT1,  FC_P,   3, 2, 255, 4095, FC_P,   4080, 16380, 0, 0);
    tab_b[3]  = mk(1, DLLP_INIT1,  FC_P,   0, 0, 7,   7,    FC_X,   4080, 16380, 0, 0);
    tab_b[4]  = mk(1, DLLP_INIT1,  FC_NP,  0, 0, 15,  1000, FC_NP,  15,   1000,  0, 0);
    tab_b[5]  = mk(1, DLLP_INIT1,  FC_CPL, 0, 0, 0,   0,    FC_CPL, 0,    0,     0, 0);
    tab_b[6]  = mk(0, DLLP_INIT1,  FC_P,   0, 0, 0,   0,    FC_X,   0,    0,     0, 0);
    tab_b[7]  = mk(1, DLLP_INIT1,  FC_P,   0, 0, 3,   3,    FC_X,   0,    0,     0, 0);
    tab_b[8]  = mk(1, DLLP_UPDATE, FC_NP,  0, 0, 20,  500,  FC_NP,  20,   500,   0, 1);
    tab_b[9]  = mk(1, DLLP_UPDATE, FC_CPL, 0, 0, 5,   0,    FC_CPL, 20,   500,   1, 1);
    tab_b[10] = mk(1, DLLP_UPDATE, FC_P,   2, 3, 1,   3,    FC_P,   4,    48,    0, 1);
    tab_b[11] = mk(1, DLLP_INIT2,  FC_P,   0, 0, 9,   9,    FC_X,   4,    48,    0, 1);
    tab_b[12] = mk(1, DLLP_UPDATE, FC_CPL, 0, 0, 0,   0,    FC_CPL, 4,    48,    0, 1);
    tab_b[13] = mk(1, DLLP_UPDATE, FC_NP,  1, 1, 7,   9,    FC_NP,  7,    9,     0, 1);

    // Reset values while reset is held.
    #12;
    chk("rst.type",     int'(TypeFC), 3);
    chk("rst.hdr",      int'(HdrFC), 0);
    chk("rst.data",     int'(DataFC), 0);
    chk("rst.done",     int'(fc_init_done), 0);
    chk("rst.inf",      int'({hdr_inf, data_inf}), 0);
    chk("rst.timeout",  int'(fc_init_timeout), 0);
    chk("rst.err",      int'(fc_proto_err), 0);
    @(negedge clk);
    arst = 1'b0;

    for (int i = 0; i < 5; i++) run(tab_a[i], $sformatf("A%0d", i));

    do_reset();
    for (int i = 0; i < 14; i++) run(tab_b[i], $sformatf("B%0d", i));
    chk("B.hdr_inf",  int'(hdr_inf), 4);
    chk("B.data_inf", int'(data_inf), 4);

    // Reset mid-sequence clears flags and the partial type mask.
    do_reset();
    run(mk(1, DLLP_INIT1, FC_P,  0, 0, 0, 0, FC_P,  0, 0, 0, 0), "R0");
    run(mk(1, DLLP_INIT1, FC_NP, 0, 0, 0, 5, FC_NP, 0, 5, 0, 0), "R1");
    chk("R.inf_before", int'(hdr_inf), 3);
    arst = 1'b1;
    #1;
    chk("R.async_type", int'(TypeFC), 3);
    chk("R.async_data", int'(DataFC), 0);
    chk("R.async_inf",  int'({hdr_inf, data_inf}), 0);
    @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    run(mk(1, DLLP_INIT1,  FC_CPL, 0, 0, 1, 1, FC_CPL, 1, 1, 0, 0), "R2");
    run(mk(1, DLLP_UPDATE, FC_P,   0, 0, 2, 2, FC_X,   1, 1, 1, 0), "R3");
    run(mk(1, DLLP_INIT1,  FC_P,   0, 0, 3, 3, FC_P,   3, 3, 0, 0), "R4");
    run(mk(1, DLLP_INIT1,  FC_NP,  0, 0, 4, 4, FC_NP,  4, 4, 0, 0), "R5");
    run(mk(1, DLLP_UPDATE, FC_P,   0, 0, 5, 5, FC_P,   5, 5, 0, 1), "R6");

    // Init timeout: no InitFC1 ever arrives.
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      if (c == 15) chk("T.before", int'(fc_init_timeout), 0);
      if (c == 16) chk("T.at",     int'(fc_init_timeout), 1);
    end
    repeat (10) @(posedge clk);
    #1;
    chk("T.sticky", int'(fc_init_timeout), 1);
    chk("T.done",   int'(fc_init_done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tx_fc_dllp_decoder.md
Name: tx_fc_dllp_decoder

Overview:
- Upstream neighbour of Tx_FC, between the Data Link Layer receive-DLLP path and Tx_FC's credit-limit port (TypeFC/HdrFC/DataFC).
- Accepts decoded InitFC1/InitFC2/UpdateFC DLLP fields and runs the FC initialization state machine.
- Applies Gen5 scaled flow control and tracks infinite credits.
- Emits one registered credit-limit update per cycle to Tx_FC, plus init-done, infinite-credit and error status.

Parameters:
- FC_HDR_WIDTH, 12, width of scaled header credit limit (8-bit raw field + 4 scale bits).
- FC_DATA_WIDTH, 16, width of scaled data credit limit (12-bit raw field + 4 scale bits).
- INIT_TIMEOUT, 4096, cycles allowed in FC_INIT1 before the timeout flag asserts.

Ports:
- clk  in  1  clock
- arst  in  1  asynchronous reset, active-high
- dllp_valid  in  1  one FC DLLP presented this cycle; no backpressure, always accepted
- dllp_kind  in  2  fc_dllp_kind_t: DLLP_INIT1, DLLP_INIT2, DLLP_UPDATE
- dllp_type  in  2  FC_type_t: FC_P, FC_NP, FC_CPL; FC_X is illegal
- dllp_hdr_scale  in  2  HdrScale field
- dllp_data_scale  in  2  DataScale field
- dllp_hdr_fc  in  8  raw HdrFC field
- dllp_data_fc  in  12  raw DataFC field
- TypeFC  out  2  FC_type_t of the update this cycle; FC_X means no update
- HdrFC  out  FC_HDR_WIDTH  scaled header credit limit
- DataFC  out  FC_DATA_WIDTH  scaled data credit limit
- fc_init_done  out  1  high in FC_READY
- hdr_inf  out  3  per-type infinite header credits, bit order {CPL, NP, P}
- data_inf  out  3  per-type infinite data credits, bit order {CPL, NP, P}
- fc_init_timeout  out  1  sticky timeout flag
- fc_proto_err  out  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset (async, arst=1): state FC_INIT1; TypeFC=FC_X; HdrFC=0; DataFC=0; all flags 0; recorded-type mask 0; timeout counter 0.
- Scaling, computed combinationally and registered:
  - scale 0 or 1: value << 0
  - scale 2: value << 2
  - scale 3: value << 4
  - Zero-extend to the output width; no truncation is possible.
- Latency: an accepted DLLP that produces an update appears on TypeFC/HdrFC/DataFC exactly 1 cycle later, for 1 cycle. TypeFC returns to FC_X the next cycle unless a new update follows.
- FSM state FC_INIT1:
  - DLLP_INIT1 for a type not yet in the mask: record the type, forward the update, set hdr_inf/data_inf for each raw field == 0.
  - Duplicate INIT1 for an already-recorded type: ignored; no output, no error.
  - INIT2 or UPDATE: dropped, fc_proto_err pulses.
  - When the mask becomes 111 (may be the same cycle as the third INIT1 is accepted), the next state is FC_INIT2.
- FSM state FC_INIT2:
  - INIT1: ignored.
  - The first INIT2 or UPDATE of any type moves to FC_READY.
  - An UPDATE received here is also processed exactly as in FC_READY.
- FSM state FC_READY:
  - fc_init_done=1.
  - UPDATE: forwarded, except that each field whose infinite flag is set keeps the old output value for that field.
  - If an infinite field receives a nonzero raw value: fc_proto_err pulses, the value is ignored, and the other field is still forwarded.
  - INIT1 and INIT2: ignored.
- dllp_type == FC_X with dllp_valid: dropped in every state, fc_proto_err pulses.
- Timeout counter:
  - Counts every cycle in FC_INIT1 and saturates at INIT_TIMEOUT.
  - Reaching INIT_TIMEOUT sets fc_init_timeout, which stays set until reset.
  - The FSM keeps waiting after timeout; there is no auto-recovery.
- Infinite flags: set only in FC_INIT1, cleared only by reset.
- HdrFC/DataFC hold their last forwarded value while TypeFC=FC_X.
- Reset asserted mid-sequence: immediate return to the reset values; the partial mask is lost.

Decomposition:
- Add to Tx_Arbiter_Package: fc_dllp_kind_t, fc_init_state_t (FC_INIT1, FC_INIT2, FC_READY), and a scale-function fc_scale(value, scale, width) shared with the receive-side FC logic.
- Reuse the existing FC_type_t from the same package.
- One natural sub-module: tx_fc_scaler, the combinational scale/zero-extend with infinite detection. Instantiate it once for the header field and once for the data field.
- FSM, mask, counter and output registers stay in the top.

Test Plan:
- INIT1 sequence:
  - Stimulus: INIT1 P(hdr 30, data 1000, scales 0), then NP(15, 1000), then CPL(30, 1000) on consecutive cycles.
  - Response: TypeFC FC_P/FC_NP/FC_CPL one cycle later with HdrFC=30/15/30 and DataFC=1000; state FC_INIT2; fc_init_done=0.
- Leaving INIT2:
  - Stimulus: from FC_INIT2, UPDATE NP(hdr 20, data 500).
  - Response: FC_READY; fc_init_done=1 the next cycle; output FC_NP/20/500 one cycle later.
- Scaling and duplicates:
  - Stimulus: INIT1 P with hdr_scale=3, hdr 255, data_scale=2, data 4095.
  - Response: HdrFC=4080, DataFC=16380.
  - Stimulus: a duplicate INIT1 P(hdr 7).
  - Response: no output, mask unchanged.
- Infinite credits:
  - Stimulus: INIT1 CPL with hdr 0 and data 0, then UPDATE CPL with hdr 5, data 0 in FC_READY.
  - Response: hdr_inf[2]=1 and data_inf[2]=1; on the UPDATE, fc_proto_err pulses once and HdrFC/DataFC keep their previous values.
- Errors and timeout:
  - Stimulus: UPDATE P in FC_INIT1.
  - Response: dropped, fc_proto_err pulses.
  - Stimulus (INIT_TIMEOUT=16): no INIT1 at all.
  - Response: fc_init_timeout rises after 16 cycles and stays high.
- Reset mid-operation:
  - Stimulus: arst pulsed after two INIT1s.
  - Response: all outputs return to reset values asynchronously; a later full INIT1 sequence is needed to reach FC_INIT2.
